// File: rtl/fifo_reader.sv
// fifo_reader: pops words from an upstream FIFO into a 2-entry in-order
// holding buffer and presents them downstream with a valid/ready handshake.
// A FIFO error halts popping (sticky error_out) until clear_err; words
// already requested are still captured and drained.
//
// Ports:
//   clk            rising-edge clock
//   reset_L        asynchronous active-low reset
//   enable         permits popping when high
//   Fifo_Data_out  FIFO read data, valid the cycle after pop is sampled
//   Fifo_Empty     FIFO holds no entries
//   Fifo_Error     FIFO overflow/underflow flag
//   ready_in       downstream accepts data_out this cycle
//   clear_err      pulse that clears the sticky error
//   pop            FIFO read strobe (combinational)
//   data_out       head of the holding buffer
//   valid_out      data_out holds a valid word
//   error_out      sticky error indication
//   pop_count      number of pops issued, wrapping
module fifo_reader (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       enable,
    input  logic [5:0] Fifo_Data_out,
    input  logic       Fifo_Empty,
    input  logic       Fifo_Error,
    input  logic       ready_in,
    input  logic       clear_err,
    output logic       pop,
    output logic [5:0] data_out,
    output logic       valid_out,
    output logic       error_out,
    output logic [7:0] pop_count
);

    localparam int unsigned DW = 6;
    localparam int unsigned CW = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          err_d;
    logic [1:0]    occ_q, occ_d;
    logic          inflight_q;
    logic [DW-1:0] buf0_q, buf1_q, buf0_d, buf1_d;
    logic          valid_d;
    logic          xfer;

    // Pop only when the buffer has room for everything already requested;
    // a same-cycle downstream transfer earns no credit.
    always_comb begin
        pop = (state_q == RUN) && enable && !Fifo_Empty &&
              ((3'(occ_q) + 3'(inflight_q)) < 3'd2);
    end

    // Next state and sticky error; Fifo_Error outranks clear_err.
    always_comb begin
        state_d = state_q;
        err_d   = error_out;
        if (Fifo_Error) begin
            state_d = HALT;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (enable && !error_out) state_d = RUN;
                RUN:  if (!enable) state_d = IDLE;
                HALT: if (clear_err) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding buffer: buf0 is the head. The head only shifts when a second
    // word exists, so data_out keeps the last head once the buffer empties.
    always_comb begin
        xfer    = valid_out && ready_in;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        if (xfer && (occ_q == 2'd2)) buf0_d = buf1_q;
        if (inflight_q) begin
            if ((occ_q == 2'd0) || ((occ_q == 2'd1) && xfer))
                buf0_d = Fifo_Data_out;
            else
                buf1_d = Fifo_Data_out;
        end
        occ_d   = occ_q + 2'(inflight_q) - 2'(xfer);
        valid_d = (occ_d != 2'd0);
    end

    // State, buffer and counter registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= IDLE;
            error_out  <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            valid_out  <= 1'b0;
            pop_count  <= '0;
        end else begin
            state_q    <= state_d;
            error_out  <= err_d;
            occ_q      <= occ_d;
            inflight_q <= pop;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            valid_out  <= valid_d;
            pop_count  <= pop_count + CW'(pop);
        end
    end

    assign data_out = buf0_q;

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port enable, input, 1 bit: permits popping when high.
REQ-004 SHALL have port Fifo_Data_out, input, 6 bits: FIFO read data, valid the cycle after pop is sampled high.
REQ-005 SHALL have port Fifo_Empty, input, 1 bit: FIFO holds no entries.
REQ-006 SHALL have port Fifo_Error, input, 1 bit: FIFO overflow/underflow flag.
REQ-007 SHALL have port ready_in, input, 1 bit: downstream accepts data_out this cycle.
REQ-008 SHALL have port clear_err, input, 1 bit: single-cycle pulse that clears the sticky error.
REQ-009 SHALL have port pop, output, 1 bit: FIFO read strobe.
REQ-010 SHALL have port data_out, output, 6 bits: head of the internal buffer.
REQ-011 SHALL have port valid_out, output, 1 bit: data_out holds a valid word.
REQ-012 SHALL have port error_out, output, 1 bit: sticky error indication.
REQ-013 SHALL have port pop_count, output, 8 bits: total number of pops issued.

Function
REQ-014 SHALL contain a 2-entry in-order holding buffer with a 2-bit occupancy counter (0..2) and a 1-bit in-flight flag; the in-flight flag is the pop value registered from the previous cycle.
REQ-015 SHALL implement states IDLE, RUN and HALT.
REQ-016 SHALL make these state transitions:
- IDLE->RUN when enable=1 and error_out=0.
- RUN->IDLE when enable=0.
- RUN or IDLE->HALT when Fifo_Error=1 is sampled.
- HALT->IDLE on clear_err=1.
REQ-017 SHALL drive pop combinationally as (state==RUN) and enable and !Fifo_Empty and (occupancy + in-flight < 2), with no credit given for a same-cycle downstream transfer.
REQ-018 SHALL write Fifo_Data_out into the buffer tail on every edge where the in-flight flag is 1, regardless of state.
REQ-019 SHALL set valid_out = (occupancy != 0) and data_out = buffer head; data_out is undefined-free (holds the last head) when valid_out=0.
REQ-020 SHALL treat a transfer as valid_out and ready_in sampled high together, removing the head on that edge.
REQ-021 SHALL leave occupancy unchanged on a simultaneous capture and transfer, with order preserved.
REQ-022 SHALL never exceed an occupancy of 2; a capture can never be dropped.
REQ-023 SHALL hold data_out stable while valid_out=1 and ready_in=0.
REQ-024 SHALL increment pop_count on every edge where pop=1, wrapping 8'hFF->8'h00.
REQ-025 SHALL set error_out on the edge Fifo_Error=1 is sampled.
REQ-026 SHALL clear error_out only via clear_err; if clear_err and Fifo_Error coincide, Fifo_Error wins (error_out stays 1, state HALT).
REQ-027 SHALL force pop=0 in HALT while still completing the in-flight capture and continuing to drain the buffer downstream.

Reset
REQ-028 SHALL, while reset_L=0 and independent of clk, drive: state=IDLE, pop=0, valid_out=0, data_out=6'h00, error_out=0, pop_count=8'h00, occupancy=0, in-flight=0.
REQ-029 SHALL discard the buffer contents and any in-flight word on reset asserted mid-operation; the first pop after release occurs no earlier than the second rising edge after reset_L rises.

Verification
REQ-030 SHALL cover basic drain: FIFO preloaded with 6'h11, 6'h16, 6'h30, 6'h1C, enable=1, ready_in=1 -> four pops; data_out presents 11,16,30,1C in order; pop_count=4; pop=0 once Fifo_Empty=1.
REQ-031 SHALL cover backpressure: ready_in=0 with 4 FIFO entries -> exactly 2 pops, then pop stays 0; occupancy=2; data_out=6'h11 held; after ready_in=1 the remaining words arrive in order with none lost.
REQ-032 SHALL cover concurrent write and read: FIFO pushed 6'h1A, 6'h1B, 6'h1C while the reader runs with ready_in=1 -> output 1A,1B,1C with no duplicates or gaps.
REQ-033 SHALL cover an error: Fifo_Error pulsed one cycle mid-stream -> error_out=1 next edge; pop=0 thereafter; buffered words still delivered; clear_err -> IDLE; re-enable resumes popping.
REQ-034 SHALL cover reset mid-stream: reset_L=0 with occupancy=2 and in-flight=1 -> valid_out=0, pop=0, pop_count=0 immediately, without waiting for a clock edge.
REQ-035 SHALL cover counter wrap: 256 pops -> pop_count returns to 8'h00.
